// File: rtl/cordic_pkg.sv
// Shared constants and result record for the CORDIC post-processing slice.
// Gain constants are Q3.30 reciprocals of the CORDIC gains.
package cordic_pkg;

  localparam logic signed [1:0] HYPERBOLIC = 2'sb11;
  localparam logic signed [1:0] LINEAR     = 2'sb00;
  localparam logic signed [1:0] CIRCULAR   = 2'sb01;
  localparam logic signed [1:0] ILLEGAL    = 2'sb10;

  localparam int K_FRAC_BITS = 30;
  localparam logic signed [32:0] INV_K_CIRC = 33'sd652032874;
  localparam logic signed [32:0] INV_K_HYP  = 33'sd1296540103;

  localparam int RES_BITS = 33;

  typedef struct packed {
    logic signed [RES_BITS-1:0] res0;
    logic signed [RES_BITS-1:0] res1;
    logic                       pair;
    logic [1:0]                 mode;
    logic                       rot_en;
  } result_t;

  // Re-scale a Q.30 gain constant to another fraction width.
  function automatic logic signed [63:0] scale_gain(input logic signed [32:0] k, input int frac_bits);
    logic signed [63:0] w;
    w = 64'(k);
    if (frac_bits >= K_FRAC_BITS) begin
      return w <<< (frac_bits - K_FRAC_BITS);
    end else begin
      return w >>> (K_FRAC_BITS - frac_bits);
    end
  endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Synchronous show-ahead FIFO for packed result records (field order as result_t).
// Status flags are registered from the next occupancy, so they never depend on rd_en combinationally.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int W         = $bits(result_t),
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          valid_r;
  logic          full_r;
  logic          af_r;
  logic          push_s;
  logic          pop_s;

  // A write into a full FIFO still succeeds when a pop frees the head slot this cycle.
  always_comb begin
    pop_s        = rd_en && valid_r;
    push_s       = wr_en && (!full_r || pop_s);
    drop         = wr_en && full_r && !pop_s;
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1'b1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
      full_r  <= (count_next_s == CW'(DEPTH));
      af_r    <= (count_next_s >= CW'(DEPTH - AF_MARGIN));
    end
  end

  // Storage array; contents are only observed through the head when valid.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data     = mem_r[rd_ptr_r];
  assign valid       = valid_r;
  assign count       = count_r;
  assign full        = full_r;
  assign almost_full = af_r;

endmodule

// File: rtl/cordic_post_proc.sv
// CORDIC result post-processor: gain correction, result selection and a show-ahead result FIFO.
// Stage 1 forms the gain product, stage 2 rounds/saturates/selects, the FIFO write follows.
module cordic_post_proc
  import cordic_pkg::*;
#(
  parameter int BITS            = 33,
  parameter int INTEGER_BITS    = 3,
  parameter int FRACTIONAL_BITS = BITS - INTEGER_BITS,
  parameter int DEPTH           = 8,
  parameter int AF_MARGIN       = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic signed [BITS-1:0] i_x,
  input  logic signed [BITS-1:0] i_y,
  input  logic signed [BITS-1:0] i_z,
  input  logic signed [1:0]      i_mode,
  input  logic                   i_rot_en,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic signed [BITS-1:0] o_res0,
  output logic signed [BITS-1:0] o_res1,
  output logic                   o_pair,
  output logic [1:0]             o_mode,
  output logic                   o_rot_en,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic                   o_overflow,
  output logic                   o_mode_err
);

  localparam int PW = 2 * BITS;
  localparam int RW = 2 * BITS + 1;
  localparam int W  = 2 * BITS + 4;
  localparam logic signed [BITS-1:0] GAIN_HYP_C  = BITS'(scale_gain(INV_K_HYP, FRACTIONAL_BITS));
  localparam logic signed [BITS-1:0] GAIN_CIRC_C = BITS'(scale_gain(INV_K_CIRC, FRACTIONAL_BITS));
  localparam logic signed [RW-1:0]   HALF_C      = RW'(1'b1) << (FRACTIONAL_BITS - 1);
  localparam logic signed [RW-1:0]   SAT_MAX_C   = RW'({1'b0, {(BITS-1){1'b1}}});
  localparam logic signed [RW-1:0]   SAT_MIN_C   = ~SAT_MAX_C;

  logic signed [BITS-1:0] gain_s;
  logic                   s1_valid_r;
  logic signed [PW-1:0]   s1_prod_r;
  logic signed [BITS-1:0] s1_x_r, s1_y_r, s1_z_r;
  logic [1:0]             s1_mode_r;
  logic                   s1_rot_r;
  logic signed [RW-1:0]   rnd_s;
  logic signed [BITS-1:0] sat_s, res0_s, res1_s;
  logic                   pair_s;
  logic                   s2_valid_r;
  logic [W-1:0]           s2_data_r;
  logic [W-1:0]           head_s;
  logic                   fifo_valid_s, fifo_drop_s;
  logic                   overflow_r, mode_err_r;

  // Gain for the vectoring-mode magnitude correction; unused paths multiply by zero.
  always_comb begin
    case (i_mode)
      HYPERBOLIC: gain_s = GAIN_HYP_C;
      CIRCULAR:   gain_s = GAIN_CIRC_C;
      default:    gain_s = '0;
    endcase
  end

  // Pipeline valid bits and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      mode_err_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      s1_valid_r <= i_valid && (i_mode != ILLEGAL);
      s2_valid_r <= s1_valid_r;
      if (i_valid && (i_mode == ILLEGAL)) mode_err_r <= 1'b1;
      if (fifo_drop_s) overflow_r <= 1'b1;
    end
  end

  // Stage-1 data: full-width signed product plus the operands needed for selection.
  always_ff @(posedge i_clk) begin
    s1_prod_r <= PW'(i_x) * PW'(gain_s);
    s1_x_r    <= i_x;
    s1_y_r    <= i_y;
    s1_z_r    <= i_z;
    s1_mode_r <= i_mode;
    s1_rot_r  <= i_rot_en;
  end

  // Round half-up, saturate the gain product, and pick the results for this mode.
  always_comb begin
    rnd_s = (RW'(s1_prod_r) + HALF_C) >>> FRACTIONAL_BITS;
    if (rnd_s > SAT_MAX_C) begin
      sat_s = SAT_MAX_C[BITS-1:0];
    end else if (rnd_s < SAT_MIN_C) begin
      sat_s = SAT_MIN_C[BITS-1:0];
    end else begin
      sat_s = rnd_s[BITS-1:0];
    end
    if (s1_mode_r == LINEAR) begin
      res0_s = s1_rot_r ? s1_y_r : s1_z_r;
      res1_s = '0;
      pair_s = 1'b0;
    end else if (s1_rot_r) begin
      res0_s = s1_x_r;
      res1_s = s1_y_r;
      pair_s = 1'b1;
    end else begin
      res0_s = s1_z_r;
      res1_s = sat_s;
      pair_s = 1'b1;
    end
  end

  // Stage-2 result record.
  always_ff @(posedge i_clk) begin
    s2_data_r <= {res0_s, res1_s, pair_s, s1_mode_r, s1_rot_r};
  end

  cordic_result_fifo #(
    .W         (W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (i_clk),
    .rst         (i_rst),
    .wr_en       (s2_valid_r),
    .wr_data     (s2_data_r),
    .rd_en       (i_ready),
    .rd_data     (head_s),
    .valid       (fifo_valid_s),
    .count       (o_count),
    .full        (o_full),
    .almost_full (o_almost_full),
    .drop        (fifo_drop_s)
  );

  // Present the head only while valid so idle outputs read as zero.
  always_comb begin
    if (fifo_valid_s) begin
      {o_res0, o_res1, o_pair, o_mode, o_rot_en} = head_s;
    end else begin
      {o_res0, o_res1, o_pair, o_mode, o_rot_en} = '0;
    end
  end

  assign o_valid    = fifo_valid_s;
  assign o_overflow = overflow_r;
  assign o_mode_err = mode_err_r;

endmodule
